// File: rtl/codec_i2c_sequencer_if.sv
// Control and codec-bus signals between the WM8731 I2C sequencer and its surroundings.
interface codec_i2c_sequencer_if;
  logic       start;
  logic       vol_set;
  logic [6:0] vol;
  logic       i2c_sdat_in;
  logic       i2c_sclk;
  logic       i2c_sdat_oe;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  start, vol_set, vol, i2c_sdat_in,
    output i2c_sclk, i2c_sdat_oe, busy, done, error
  );

  modport slave (
    output start, vol_set, vol, i2c_sdat_in,
    input  i2c_sclk, i2c_sdat_oe, busy, done, error
  );
endinterface

// File: rtl/codec_i2c_sequencer.sv
// WM8731 configuration over 100 kHz I2C: power-on register table, then headphone-volume updates.
// Every bus edge is aligned to a quarter-bit tick from the clk18 divider.
module codec_i2c_sequencer #(
  parameter int unsigned CLKDIV    = 45,
  parameter logic [15:0] POR_TICKS = 16'd4000,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter logic [1:0]  MAX_TRY   = 2'd3
) (
  input  logic                         clk18,
  input  logic                         reset_n,
  codec_i2c_sequencer_if.master        bus
);

  // state  | meaning
  // POR    | power-on wait before the first table word
  // IDLE   | bus released, waiting for start or a volume request
  // START  | start condition (2 ticks)
  // BIT    | one data bit, 4 quarter ticks
  // ACK    | acknowledge slot, SDA released, sampled at q2
  // STOP   | stop condition (3 ticks)
  // GAP    | 4 idle ticks, then choose retry / next word / finish
  // FAIL   | word NACKed MAX_TRY times, flag error
  typedef enum logic [2:0] {
    S_POR, S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_FAIL
  } state_t;

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  state_t      r_state;
  logic [1:0]  r_q;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [3:0]  r_idx;
  logic [1:0]  r_try;
  logic [15:0] r_por_cnt;
  logic [7:0]  r_shift;
  logic        r_nack;
  logic        r_sclk;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_vol_pend;
  logic [6:0]  r_vol_val;
  logic [6:0]  r_vol_cur;
  logic        r_vol_mode;
  logic        r_vol_phase;

  logic [15:0] w_word;
  logic        w_last;

  assign w_tick = (r_div == DIV_W'(CLKDIV - 1));

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n)    r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  function automatic logic [15:0] tbl_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {7'd15, 9'h000};
      4'd1:    w = {7'd0,  9'h017};
      4'd2:    w = {7'd1,  9'h017};
      4'd3:    w = {7'd2,  9'h079};
      4'd4:    w = {7'd3,  9'h079};
      4'd5:    w = {7'd4,  9'h012};
      4'd6:    w = {7'd5,  9'h000};
      4'd7:    w = {7'd6,  9'h000};
      4'd8:    w = {7'd7,  9'h002};
      4'd9:    w = {7'd8,  9'h000};
      4'd10:   w = {7'd9,  9'h001};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign w_word = r_vol_mode ? {(r_vol_phase ? 7'd3 : 7'd2), 2'b00, r_vol_cur}
                             : tbl_word(r_idx);
  assign w_last = r_vol_mode ? r_vol_phase : (r_idx == 4'd10);

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_POR;
      r_q         <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_idx       <= '0;
      r_try       <= '0;
      r_por_cnt   <= '0;
      r_shift     <= '0;
      r_nack      <= 1'b0;
      r_sclk      <= 1'b1;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_vol_pend  <= 1'b0;
      r_vol_val   <= '0;
      r_vol_cur   <= '0;
      r_vol_mode  <= 1'b0;
      r_vol_phase <= 1'b0;
    end else begin
      case (r_state)
        S_POR: begin
          r_busy <= 1'b1;
          if (w_tick) begin
            if (r_por_cnt == POR_TICKS - 16'd1) begin
              r_state    <= S_START;
              r_idx      <= '0;
              r_vol_mode <= 1'b0;
              r_try      <= '0;
              r_q        <= '0;
            end else begin
              r_por_cnt <= r_por_cnt + 16'd1;
            end
          end
        end

        S_IDLE: begin
          if (bus.start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_vol_mode <= 1'b0;
            r_try      <= '0;
            r_q        <= '0;
            r_state    <= S_START;
          end else if (r_done && r_vol_pend) begin
            r_vol_mode  <= 1'b1;
            r_vol_phase <= 1'b0;
            r_vol_cur   <= r_vol_val;
            r_vol_pend  <= 1'b0;
            r_busy      <= 1'b1;
            r_try       <= '0;
            r_q         <= '0;
            r_state     <= S_START;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (r_q == 2'd0) begin
              r_oe   <= 1'b1;
              r_sclk <= 1'b1;
              r_q    <= 2'd1;
            end else begin
              r_sclk  <= 1'b0;
              r_shift <= {DEV_ADDR, 1'b0};
              r_bit   <= '0;
              r_byte  <= '0;
              r_nack  <= 1'b0;
              r_q     <= '0;
              r_state <= S_BIT;
            end
          end
        end

        S_BIT: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_oe   <= ~r_shift[7];
              2'd1: r_sclk <= 1'b1;
              2'd2: r_sclk <= 1'b1;
              default: begin
                r_sclk <= 1'b0;
                if (r_bit == 3'd7) begin
                  r_state <= S_ACK;
                end else begin
                  r_shift <= {r_shift[6:0], 1'b0};
                  r_bit   <= r_bit + 3'd1;
                end
              end
            endcase
          end
        end

        S_ACK: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_oe   <= 1'b0;
              2'd1: r_sclk <= 1'b1;
              2'd2: r_nack <= bus.i2c_sdat_in;
              default: begin
                r_sclk <= 1'b0;
                if (r_nack || r_byte == 2'd2) begin
                  r_state <= S_STOP;
                end else begin
                  r_shift <= (r_byte == 2'd0) ? w_word[15:8] : w_word[7:0];
                  r_byte  <= r_byte + 2'd1;
                  r_bit   <= '0;
                  r_state <= S_BIT;
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_oe   <= 1'b1;
                r_sclk <= 1'b0;
                r_q    <= 2'd1;
              end
              2'd1: begin
                r_sclk <= 1'b1;
                r_q    <= 2'd2;
              end
              default: begin
                r_oe    <= 1'b0;
                r_q     <= '0;
                r_state <= S_GAP;
              end
            endcase
          end
        end

        S_GAP: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd3) begin
              if (r_nack) begin
                if (r_try == MAX_TRY - 2'd1) begin
                  r_state <= S_FAIL;
                end else begin
                  r_try   <= r_try + 2'd1;
                  r_state <= S_START;
                end
              end else begin
                r_try <= '0;
                if (w_last) begin
                  if (!r_vol_mode) r_done <= 1'b1;
                  // Chain straight into a queued volume pair so busy never dips between them.
                  if (r_vol_pend) begin
                    r_vol_mode  <= 1'b1;
                    r_vol_phase <= 1'b0;
                    r_vol_cur   <= r_vol_val;
                    r_vol_pend  <= 1'b0;
                    r_state     <= S_START;
                  end else begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                  end
                end else if (r_vol_mode) begin
                  r_vol_phase <= 1'b1;
                  r_state     <= S_START;
                end else begin
                  r_idx   <= r_idx + 4'd1;
                  r_state <= S_START;
                end
              end
            end
          end
        end

        S_FAIL: begin
          r_error    <= 1'b1;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_vol_pend <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      if (bus.vol_set) begin
        r_vol_pend <= 1'b1;
        r_vol_val  <= bus.vol;
      end
    end
  end

  assign bus.i2c_sclk    = r_sclk;
  assign bus.i2c_sdat_oe = r_oe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// Bench for codec_i2c_sequencer: I2C slave model logs each transaction; expected words come from the register table.
module tb_codec_i2c_sequencer;
  localparam int CLKDIV = 2;
  localparam int WORD_TICKS = 117;

  logic clk18 = 1'b0;
  logic reset_n;
  always #5 clk18 = ~clk18;

  codec_i2c_sequencer_if bus();

  codec_i2c_sequencer #(.CLKDIV(CLKDIV), .POR_TICKS(16'd4)) dut (
    .clk18  (clk18),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

  logic slv_pull = 1'b0;
  assign bus.i2c_sdat_in = ~bus.i2c_sdat_oe & ~slv_pull;

  // transaction log written only by the slave model
  logic [23:0] log_bits [256];
  int          log_nb   [256];
  int          log_cyc  [256];
  int          log_wr = 0;

  int pol_word = -1, pol_byte = 0, pol_times = 0, clr_req = 0;

  int cyc = 0;
  always @(posedge clk18) cyc <= cyc + 1;

  int          bitn = 0, nbytes = 0, good_cnt = 0, nack_given = 0, clr_seen = 0, start_cyc = 0;
  logic [7:0]  cur = '0;
  logic [23:0] bits = '0;
  logic        in_txn = 1'b0, nacked = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk18) begin
    if (clr_req != clr_seen) begin
      clr_seen   = clr_req;
      good_cnt   = 0;
      nack_given = 0;
    end
    if (!reset_n) begin
      in_txn   = 1'b0;
      slv_pull = 1'b0;
      bitn     = 0;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
    end else begin
      if (prev_scl && bus.i2c_sclk && prev_sda && !bus.i2c_sdat_in) begin
        in_txn = 1'b1; bitn = 0; nbytes = 0; bits = '0; cur = '0; nacked = 1'b0;
        start_cyc = cyc;
      end else if (prev_scl && bus.i2c_sclk && !prev_sda && bus.i2c_sdat_in) begin
        if (in_txn && log_wr < 256) begin
          log_bits[log_wr] = bits;
          log_nb[log_wr]   = nbytes;
          log_cyc[log_wr]  = start_cyc;
          log_wr++;
          if (!nacked) good_cnt++;
        end
        in_txn = 1'b0;
      end else if (in_txn && !prev_scl && bus.i2c_sclk) begin
        if (bitn < 8) cur = {cur[6:0], bus.i2c_sdat_in};
        bitn++;
      end else if (in_txn && prev_scl && !bus.i2c_sclk) begin
        if (bitn == 8) begin
          bits = {bits[15:0], cur};
          nbytes++;
          if (good_cnt == pol_word && nbytes - 1 == pol_byte && nack_given < pol_times) begin
            nacked   = 1'b1;
            nack_given++;
            slv_pull = 1'b0;
          end else begin
            slv_pull = 1'b1;
          end
        end else if (bitn == 9) begin
          slv_pull = 1'b0;
          bitn     = 0;
        end
      end
      prev_scl = bus.i2c_sclk;
      prev_sda = bus.i2c_sdat_in;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [23:0] exp_bits [$];
  int          exp_nb   [$];

  // nack_byte < 0 means the whole word is acknowledged
  task automatic exp_word(input logic [15:0] w, input int nack_byte);
    logic [23:0] full;
    int n;
    full = {8'h34, w};
    n = (nack_byte < 0) ? 3 : nack_byte + 1;
    exp_bits.push_back(full >> (8 * (3 - n)));
    exp_nb.push_back(n);
  endtask

  task automatic exp_table(input int nack_idx, input int nack_byte, input int nack_times);
    for (int i = 0; i < 11; i++) begin
      int tries;
      tries = (i == nack_idx) ? ((nack_times > 3) ? 3 : nack_times) : 0;
      for (int a = 0; a < tries; a++) exp_word(tbl[i], nack_byte);
      if (tries == 3) return;
      exp_word(tbl[i], -1);
    end
  endtask

  task automatic exp_pair(input logic [6:0] v);
    exp_word({7'd2, 2'b00, v}, -1);
    exp_word({7'd3, 2'b00, v}, -1);
  endtask

  task automatic compare_log(input string tag, input int base);
    int n;
    chk($sformatf("%s_count", tag), log_wr - base, exp_bits.size());
    n = (log_wr - base < exp_bits.size()) ? log_wr - base : exp_bits.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d_bits", tag, i), log_bits[base + i], exp_bits[i]);
      chk($sformatf("%s_w%0d_nbytes", tag, i), log_nb[base + i], exp_nb[i]);
    end
    exp_bits.delete();
    exp_nb.delete();
  endtask

  task automatic set_policy(input int w, input int b, input int t);
    pol_word  = w;
    pol_byte  = b;
    pol_times = t;
    clr_req++;
    @(negedge clk18);
  endtask

  task automatic pulse_start();
    @(negedge clk18);
    bus.start = 1'b1;
    @(negedge clk18);
    bus.start = 1'b0;
  endtask

  task automatic pulse_vol(input logic [6:0] v);
    @(negedge clk18);
    bus.vol     = v;
    bus.vol_set = 1'b1;
    @(negedge clk18);
    bus.vol_set = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clk18);
    while (bus.busy && n < 20000) begin
      @(negedge clk18);
      n++;
    end
    chk({tag, "_idle_timeout"}, bus.busy, 1'b0);
  endtask

  task automatic wait_log(input int target, input string tag);
    int n;
    n = 0;
    while (log_wr < target && n < 20000) begin
      @(negedge clk18);
      n++;
    end
    chk({tag, "_log_timeout"}, (log_wr >= target), 1'b1);
  endtask

  initial begin
    int base, nb, w, n;
    logic [6:0] v1, v2, v3, v4;
    bus.start   = 1'b0;
    bus.vol_set = 1'b0;
    bus.vol     = '0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk18);
    chk("rst_sclk", bus.i2c_sclk, 1'b1);
    chk("rst_oe", bus.i2c_sdat_oe, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_error", bus.error, 1'b0);

    // power-on table, slave always acknowledges
    base = log_wr;
    reset_n = 1'b1;
    wait_idle("t1");
    exp_table(-1, 0, 0);
    compare_log("t1", base);
    chk("t1_done", bus.done, 1'b1);
    chk("t1_busy", bus.busy, 1'b0);
    chk("t1_error", bus.error, 1'b0);
    chk("t1_word_period", log_cyc[base + 1] - log_cyc[base], WORD_TICKS * CLKDIV);

    // word 3 NACKed twice at a random byte, then accepted
    nb = $urandom_range(0, 2);
    set_policy(3, nb, 2);
    base = log_wr;
    pulse_start();
    wait_idle("t2");
    exp_table(3, nb, 2);
    compare_log("t2", base);
    chk("t2_done", bus.done, 1'b1);
    chk("t2_error", bus.error, 1'b0);

    // a random word NACKed forever; queued volume must be dropped
    w  = $urandom_range(1, 9);
    nb = $urandom_range(0, 2);
    set_policy(w, nb, 99);
    base = log_wr;
    pulse_start();
    wait_log(base + 2, "t3");
    pulse_vol(7'($urandom_range(0, 127)));
    wait_idle("t3");
    repeat (3000) @(negedge clk18);
    exp_table(w, nb, 99);
    compare_log("t3", base);
    chk("t3_error", bus.error, 1'b1);
    chk("t3_done", bus.done, 1'b0);
    chk("t3_busy", bus.busy, 1'b0);

    // restart after failure, ignored start, volume overwrite and in-flight update
    set_policy(-1, 0, 0);
    base = log_wr;
    pulse_start();
    repeat (3) @(negedge clk18);
    chk("t4_error_cleared", bus.error, 1'b0);
    chk("t4_busy", bus.busy, 1'b1);
    pulse_start();
    v1 = 7'($urandom_range(0, 127));
    v2 = 7'($urandom_range(0, 127));
    v3 = 7'($urandom_range(0, 127));
    pulse_vol(v1);
    wait_log(base + 3, "t4a");
    pulse_vol(v2);
    wait_log(base + 12, "t4b");
    pulse_vol(v3);
    wait_idle("t4");
    exp_table(-1, 0, 0);
    exp_pair(v2);
    exp_pair(v3);
    compare_log("t4", base);
    chk("t4_done", bus.done, 1'b1);
    chk("t4_busy", bus.busy, 1'b0);

    // reset in the middle of word 2, second byte, bit 5
    base = log_wr;
    pulse_start();
    wait_log(base + 2, "t5a");
    n = 0;
    while (!(in_txn && nbytes == 1 && bitn == 5) && n < 20000) begin
      @(negedge clk18);
      n++;
    end
    chk("t5_reached_bit5", (in_txn && nbytes == 1 && bitn == 5), 1'b1);
    chk("t5_words_before_reset", log_wr - base, 2);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_sclk", bus.i2c_sclk, 1'b1);
    chk("t5_rst_oe", bus.i2c_sdat_oe, 1'b0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk18);
    base = log_wr;
    reset_n = 1'b1;
    wait_idle("t5");
    exp_table(-1, 0, 0);
    compare_log("t5", base);
    chk("t5_done", bus.done, 1'b1);

    // volume request while idle
    v4 = 7'($urandom_range(0, 127));
    base = log_wr;
    pulse_vol(v4);
    wait_idle("t6");
    exp_pair(v4);
    compare_log("t6", base);
    chk("t6_done", bus.done, 1'b1);
    chk("t6_busy", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
